// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and a
// single-bit full-subtract reference function.
package sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Returns {diff, bout} for x - y - bin.
    function automatic logic [1:0] full_sub_bit(input logic x, input logic y, input logic bin);
        logic d;
        logic b;
        d = x ^ y ^ bin;
        b = (~x & y) | (~(x ^ y) & bin);
        return {d, b};
    endfunction

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// One-bit full subtractor built from two half-subtract stages whose borrows
// are ORed together.
module full_sub (
    output logic Diff,
    output logic Bout,
    input  logic X,
    input  logic Y,
    input  logic Bin
);

    logic d1;
    logic b1;
    logic b2;

    assign d1   = X ^ Y;
    assign b1   = ~X & Y;
    assign Diff = d1 ^ Bin;
    assign b2   = ~d1 & Bin;
    assign Bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: retires BITS_PER_CYC bits of X - Y - Bin per clock
// through a chain of full_sub cells, carrying the borrow in a register.
import sub_pkg::*;

module serial_subtractor #(
    parameter int WIDTH        = 8,
    parameter int BITS_PER_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Zero,
    output state_t           state_dbg
);

    localparam int STEPS = WIDTH / BITS_PER_CYC;
    localparam int CW    = $clog2(STEPS + 1);

    generate
        if (WIDTH < 1 || BITS_PER_CYC < 1 || (WIDTH % BITS_PER_CYC) != 0) begin : g_bad_params
            $error("serial_subtractor: BITS_PER_CYC must divide WIDTH");
        end
    endgenerate

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [WIDTH-1:0]    x_sh;
    logic [WIDTH-1:0]    y_sh;
    logic [WIDTH-1:0]    res_sh;
    logic                bor_q;
    logic [BITS_PER_CYC:0]   chain;
    logic [BITS_PER_CYC-1:0] dbits;
    logic [WIDTH-1:0]    res_next;

    assign chain[0] = bor_q;

    for (genvar i = 0; i < BITS_PER_CYC; i++) begin : g_cells
        full_sub u_fs (
            .Diff (dbits[i]),
            .Bout (chain[i+1]),
            .X    (x_sh[i]),
            .Y    (y_sh[i]),
            .Bin  (chain[i])
        );
    end

    // New difference bits enter at the MSB end so the result is aligned after STEPS shifts.
    assign res_next  = (res_sh >> BITS_PER_CYC) | (WIDTH'(dbits) << (WIDTH - BITS_PER_CYC));
    assign state_dbg = state;

    // Handshake: start is a request sampled only in IDLE or DONE (taken there, no
    // acknowledge beyond busy rising); done is a one-cycle strobe marking Diff/Bout/Zero
    // valid, which then hold until the following op completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            Diff   <= '0;
            Bout   <= 1'b0;
            Zero   <= 1'b0;
            cnt    <= '0;
            x_sh   <= '0;
            y_sh   <= '0;
            res_sh <= '0;
            bor_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        x_sh  <= X;
                        y_sh  <= Y;
                        bor_q <= Bin;
                        cnt   <= '0;
                        state <= S_RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    x_sh   <= x_sh >> BITS_PER_CYC;
                    y_sh   <= y_sh >> BITS_PER_CYC;
                    res_sh <= res_next;
                    bor_q  <= chain[BITS_PER_CYC];
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(STEPS - 1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        Diff  <= res_next;
                        Bout  <= chain[BITS_PER_CYC];
                        Zero  <= (res_next == '0) && !chain[BITS_PER_CYC];
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and small randomised checks of serial_subtractor across four
// parameterisations: (8,1), (8,4), (8,8) and (1,1).
import sub_pkg::*;

module tb_serial_subtractor;

    logic clk;
    logic rst_n;

    logic       start_v [4];
    logic [7:0] x_v     [4];
    logic [7:0] y_v     [4];
    logic       bin_v   [4];
    logic       busy_v  [4];
    logic       done_v  [4];
    logic [7:0] diff_v  [3];
    logic       diff1;
    logic       bout_v  [4];
    logic       zero_v  [4];
    state_t     st_v    [4];

    int checks = 0;
    int errors = 0;
    int lat;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8), .BITS_PER_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .X(x_v[0]), .Y(y_v[0]), .Bin(bin_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .Diff(diff_v[0]), .Bout(bout_v[0]), .Zero(zero_v[0]),
        .state_dbg(st_v[0])
    );

    serial_subtractor #(.WIDTH(8), .BITS_PER_CYC(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .X(x_v[1]), .Y(y_v[1]), .Bin(bin_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .Diff(diff_v[1]), .Bout(bout_v[1]), .Zero(zero_v[1]),
        .state_dbg(st_v[1])
    );

    serial_subtractor #(.WIDTH(8), .BITS_PER_CYC(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .X(x_v[2]), .Y(y_v[2]), .Bin(bin_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .Diff(diff_v[2]), .Bout(bout_v[2]), .Zero(zero_v[2]),
        .state_dbg(st_v[2])
    );

    serial_subtractor #(.WIDTH(1), .BITS_PER_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .X(x_v[3][0]), .Y(y_v[3][0]), .Bin(bin_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .Diff(diff1), .Bout(bout_v[3]), .Zero(zero_v[3]),
        .state_dbg(st_v[3])
    );

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] diff_of(input int sel);
        return (sel == 3) ? {7'b0, diff1} : diff_v[sel];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_op(input int sel, input logic [7:0] x, input logic [7:0] y, input logic b);
        @(negedge clk);
        x_v[sel]     = x;
        y_v[sel]     = y;
        bin_v[sel]   = b;
        start_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        start_v[sel] = 1'b0;
        lat = 1;
    endtask

    task automatic wait_done(input int sel, input string tag);
        logic seen;
        seen = done_v[sel];
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            seen = done_v[sel];
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic op(input int sel, input string tag, input logic [7:0] x, input logic [7:0] y,
                      input logic b, input int exp_lat, input logic [7:0] exp_d,
                      input logic exp_b, input logic exp_z);
        start_op(sel, x, y, b);
        wait_done(sel, tag);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_diff"}, 32'(diff_of(sel)), 32'(exp_d));
        chk({tag, "_bout"}, 32'(bout_v[sel]), 32'(exp_b));
        chk({tag, "_zero"}, 32'(zero_v[sel]), 32'(exp_z));
    endtask

    // Reference model for random ops on 8-bit instances.
    task automatic rand_op(input int sel, input int exp_lat);
        logic [7:0] x;
        logic [7:0] y;
        logic       b;
        logic [8:0] r;
        x = 8'($urandom_range(0, 255));
        y = 8'($urandom_range(0, 255));
        b = 1'($urandom_range(0, 1));
        r = {1'b0, x} - {1'b0, y} - {8'b0, b};
        op(sel, $sformatf("rand%0d", sel), x, y, b, exp_lat, r[7:0], r[8], (r == 9'd0));
    endtask

    // ---------------- directed sequence ----------------
    logic [7:0] bx [3];
    logic [7:0] by [3];
    logic [7:0] bd [3];
    logic       bb [3];
    int         nd;
    int         last;
    int         dones;

    initial begin
        rst_n = 1'b0;
        for (int s = 0; s < 4; s++) begin
            start_v[s] = 1'b0;
            x_v[s]     = 8'h00;
            y_v[s]     = 8'h00;
            bin_v[s]   = 1'b0;
        end
        #12;
        chk("rst_busy", 32'(busy_v[0]), 32'd0);
        chk("rst_done", 32'(done_v[0]), 32'd0);
        chk("rst_diff", 32'(diff_v[0]), 32'd0);
        chk("rst_bout", 32'(bout_v[0]), 32'd0);
        chk("rst_zero", 32'(zero_v[0]), 32'd0);
        chk("rst_state", 32'(st_v[0]), 32'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        op(0, "sub_05_03", 8'h05, 8'h03, 1'b0, 9, 8'h02, 1'b0, 1'b0);
        op(0, "sub_03_05", 8'h03, 8'h05, 1'b0, 9, 8'hFE, 1'b1, 1'b0);
        op(0, "sub_00_00_b", 8'h00, 8'h00, 1'b1, 9, 8'hFF, 1'b1, 1'b0);
        op(0, "sub_5a_5a", 8'h5A, 8'h5A, 1'b0, 9, 8'h00, 1'b0, 1'b1);
        chk("done_cycle_busy", 32'(busy_v[0]), 32'd0);
        chk("done_cycle_state", 32'(st_v[0]), 32'(S_DONE));
        @(posedge clk);
        #1;
        chk("after_done_busy", 32'(busy_v[0]), 32'd0);
        chk("after_done_pulse", 32'(done_v[0]), 32'd0);
        chk("after_done_state", 32'(st_v[0]), 32'(S_IDLE));
        chk("idle_hold_zero", 32'(zero_v[0]), 32'd1);

        // Start and operand changes during RUN are ignored.
        start_op(0, 8'h80, 8'h01, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        start_v[0] = 1'b1;
        x_v[0]     = 8'hFF;
        y_v[0]     = 8'hFF;
        bin_v[0]   = 1'b1;
        chk("midrun_busy", 32'(busy_v[0]), 32'd1);
        chk("midrun_diff_held", 32'(diff_v[0]), 32'h00);
        @(posedge clk);
        #1;
        lat++;
        start_v[0] = 1'b0;
        wait_done(0, "midrun");
        chk("midrun_latency", 32'(lat), 32'd9);
        chk("midrun_diff", 32'(diff_v[0]), 32'h7F);
        chk("midrun_bout", 32'(bout_v[0]), 32'd0);

        // Reset in RUN cycle 4 aborts and clears outputs immediately.
        start_op(0, 8'h40, 8'h01, 1'b0);
        for (int i = 0; i < 3; i++) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_diff", 32'(diff_v[0]), 32'd0);
        chk("abort_busy", 32'(busy_v[0]), 32'd0);
        chk("abort_state", 32'(st_v[0]), 32'(S_IDLE));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done_v[0]) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        op(0, "post_abort", 8'h10, 8'h01, 1'b0, 9, 8'h0F, 1'b0, 1'b0);

        // Back-to-back with start held high.
        bx[0] = 8'h20; by[0] = 8'h01; bd[0] = 8'h1F; bb[0] = 1'b0;
        bx[1] = 8'h01; by[1] = 8'h02; bd[1] = 8'hFF; bb[1] = 1'b1;
        bx[2] = 8'h77; by[2] = 8'h77; bd[2] = 8'h00; bb[2] = 1'b0;
        @(negedge clk);
        x_v[0] = bx[0]; y_v[0] = by[0]; bin_v[0] = 1'b0;
        start_v[0] = 1'b1;
        nd = 0;
        last = 0;
        for (int e = 1; e <= 40 && nd < 3; e++) begin
            @(posedge clk);
            #1;
            if (done_v[0]) begin
                chk($sformatf("b2b%0d_diff", nd), 32'(diff_v[0]), 32'(bd[nd]));
                chk($sformatf("b2b%0d_bout", nd), 32'(bout_v[0]), 32'(bb[nd]));
                chk($sformatf("b2b%0d_gap", nd), 32'(e - last), 32'd9);
                last = e;
                nd++;
                if (nd < 3) begin
                    x_v[0] = bx[nd];
                    y_v[0] = by[nd];
                end else begin
                    start_v[0] = 1'b0;
                end
            end
        end
        start_v[0] = 1'b0;
        chk("b2b_count", 32'(nd), 32'd3);
        chk("b2b_zero", 32'(zero_v[0]), 32'd1);

        // Wider retire rates.
        op(1, "bpc4_dir", 8'h03, 8'h05, 1'b0, 3, 8'hFE, 1'b1, 1'b0);
        op(2, "bpc8_dir", 8'h00, 8'h00, 1'b1, 2, 8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 25; i++) rand_op(1, 3);
        for (int i = 0; i < 25; i++) rand_op(2, 2);

        // WIDTH=1 degenerates to a registered half subtractor.
        op(3, "w1_00", 8'h00, 8'h00, 1'b0, 2, 8'h00, 1'b0, 1'b1);
        op(3, "w1_01", 8'h00, 8'h01, 1'b0, 2, 8'h01, 1'b1, 1'b0);
        op(3, "w1_10", 8'h01, 8'h00, 1'b0, 2, 8'h01, 1'b0, 1'b0);
        op(3, "w1_11", 8'h01, 8'h01, 1'b0, 2, 8'h00, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
